// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU front end: opcodes, FSM states,
// instruction field positions and register file geometry.
package alu_seq_pkg;

  localparam int unsigned RegCount = 8;
  localparam int unsigned RegWidth = 16;
  localparam int unsigned RegAddrW = 3;
  localparam int unsigned ImmWidth = 9;

  localparam int unsigned OpcMsb = 15;
  localparam int unsigned OpcLsb = 12;
  localparam int unsigned RdMsb  = 11;
  localparam int unsigned RdLsb  = 9;
  localparam int unsigned RaMsb  = 8;
  localparam int unsigned RaLsb  = 6;
  localparam int unsigned RbMsb  = 5;
  localparam int unsigned RbLsb  = 3;
  localparam int unsigned ImmMsb = 8;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_LOADI = 4'b1000;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWb
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLL) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x16 register file, two asynchronous read ports and one synchronous write port.
// With ALU_SEQ_R0_ZERO_EN defined, R0 reads as zero and writes to it are dropped.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RegAddrW-1:0] ra_addr,
  output logic [RegWidth-1:0] ra_data,
  input  logic [RegAddrW-1:0] rb_addr,
  output logic [RegWidth-1:0] rb_data,
  input  logic                we,
  input  logic [RegAddrW-1:0] wa,
  input  logic [RegWidth-1:0] wd
);

  logic [RegWidth-1:0] mem_q [RegCount];
  logic                we_eff;

`ifdef ALU_SEQ_R0_ZERO_EN
  assign we_eff  = we && (wa != '0);
  assign ra_data = (ra_addr == '0) ? '0 : mem_q[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem_q[rb_addr];
`else
  assign we_eff  = we;
  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (we_eff) begin
      mem_q[wa] <= wd;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential instruction front end driving an external combinational ALU.
// Optional macro ALU_SEQ_R0_ZERO_EN makes R0 a hard-wired zero register.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         Instr,
  input  logic                InstrValid,
  output logic                InstrReady,
  output logic [RegWidth-1:0] AluA,
  output logic [RegWidth-1:0] AluB,
  output logic [3:0]          AluOpcode,
  input  logic [RegWidth-1:0] AluOutput,
  output logic                ResValid,
  input  logic                ResReady,
  output logic [RegWidth-1:0] ResData,
  output logic [RegAddrW-1:0] ResRd,
  output logic                ResErr
);

  state_e state_q, state_d;

  logic [3:0]          op_q;
  logic [RegAddrW-1:0] rd_q;
  logic [RegWidth-1:0] a_q, b_q;
  logic [ImmWidth-1:0] imm_q;

  logic                res_valid_q;
  logic [RegWidth-1:0] res_data_q;
  logic [RegAddrW-1:0] res_rd_q;
  logic                res_err_q;

  logic                accept;
  logic                exec_done;
  logic                res_hs;
  logic [RegWidth-1:0] ra_data, rb_data;
  logic [RegWidth-1:0] wb_data;
  logic                wb_err;
  logic                rf_we;

  assign InstrReady = (state_q == StIdle);
  assign accept     = InstrReady && InstrValid;
  assign exec_done  = (state_q == StExec);
  assign res_hs     = (state_q == StWb) && res_valid_q && ResReady;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (Instr[RaMsb:RaLsb]),
    .ra_data (ra_data),
    .rb_addr (Instr[RbMsb:RbLsb]),
    .rb_data (rb_data),
    .we      (rf_we),
    .wa      (rd_q),
    .wd      (wb_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (InstrValid) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    if (res_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Result selection at the end of EXEC; the ALU output is ignored for LOADI.
  always_comb begin
    wb_data = AluOutput;
    wb_err  = 1'b0;
    if (op_q == OP_LOADI) begin
      wb_data = {{(RegWidth - ImmWidth){1'b0}}, imm_q};
    end else if (!is_alu_op(op_q)) begin
      wb_data = '0;
      wb_err  = 1'b1;
    end
  end

  assign rf_we = exec_done && !wb_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers double as the ALU drive, so they hold outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rd_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= Instr[OpcMsb:OpcLsb];
      rd_q  <= Instr[RdMsb:RdLsb];
      a_q   <= ra_data;
      b_q   <= rb_data;
      imm_q <= Instr[ImmMsb:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_err_q   <= 1'b0;
    end else if (exec_done) begin
      res_valid_q <= 1'b1;
      res_data_q  <= wb_data;
      res_rd_q    <= rd_q;
      res_err_q   <= wb_err;
    end else if (res_hs) begin
      res_valid_q <= 1'b0;
    end
  end

  assign AluA      = a_q;
  assign AluB      = b_q;
  assign AluOpcode = op_q;
  assign ResValid  = res_valid_q;
  assign ResData   = res_data_q;
  assign ResRd     = res_rd_q;
  assign ResErr    = res_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural model plus per-cycle compare,
// directed literal checks and randomized instruction traffic.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] Instr = '0;
  logic        InstrValid = 1'b0;
  logic        InstrReady;
  logic [15:0] AluA, AluB;
  logic [3:0]  AluOpcode;
  logic [15:0] AluOutput;
  logic        ResValid;
  logic        ResReady = 1'b0;
  logic [15:0] ResData;
  logic [2:0]  ResRd;
  logic        ResErr;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ALU_SEQ_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .AluA       (AluA),
    .AluB       (AluB),
    .AluOpcode  (AluOpcode),
    .AluOutput  (AluOutput),
    .ResValid   (ResValid),
    .ResReady   (ResReady),
    .ResData    (ResData),
    .ResRd      (ResRd),
    .ResErr     (ResErr)
  );

  // External ALU; a marker value for non-ALU opcodes exposes misuse of the output.
  always_comb begin
    AluOutput = 16'hDEAD;
    case (AluOpcode)
      4'h0:    AluOutput = AluA + AluB;
      4'h1:    AluOutput = AluA - AluB;
      4'h2:    AluOutput = AluA << AluB[3:0];
      4'h3:    AluOutput = AluA & AluB;
      default: AluOutput = 16'hDEAD;
    endcase
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_regs [8];
  int          m_since;   // -1 idle, 1 executing, 2 result pending
  logic [15:0] m_a, m_b;
  logic [3:0]  m_op;
  logic        m_valid, m_err, p_err;
  logic [15:0] m_data, p_data;
  logic [2:0]  m_rd, p_rd;

  function automatic logic [15:0] rd_reg(input logic [2:0] idx);
    if (R0Zero && idx == 3'd0) return 16'h0000;
    return m_regs[idx];
  endfunction

  function automatic logic [16:0] m_exec(input logic [15:0] ins);
    logic [15:0] a, b;
    a = rd_reg(ins[8:6]);
    b = rd_reg(ins[5:3]);
    case (ins[15:12])
      4'h0:    return {1'b0, a + b};
      4'h1:    return {1'b0, a - b};
      4'h2:    return {1'b0, a << b[3:0]};
      4'h3:    return {1'b0, a & b};
      4'h8:    return {1'b0, 7'b0, ins[8:0]};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= '0;
      m_since <= -1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_rd    <= '0;
      m_err   <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      m_op    <= '0;
    end else if (m_since < 0) begin
      if (InstrValid) begin
        m_since         <= 1;
        m_a             <= rd_reg(Instr[8:6]);
        m_b             <= rd_reg(Instr[5:3]);
        m_op            <= Instr[15:12];
        p_rd            <= Instr[11:9];
        {p_err, p_data} <= m_exec(Instr);
      end
    end else if (m_since == 1) begin
      m_since <= 2;
      m_valid <= 1'b1;
      m_data  <= p_data;
      m_rd    <= p_rd;
      m_err   <= p_err;
      if (!p_err && !(R0Zero && p_rd == 3'd0)) m_regs[p_rd] <= p_data;
    end else if (ResReady) begin
      m_since <= -1;
      m_valid <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) check("instr_ready", {15'b0, InstrReady}, {15'b0, m_since < 0});
    check("res_valid", {15'b0, ResValid}, {15'b0, m_valid});
    if (!rst_n || m_valid) begin
      check("res_data", ResData, m_data);
      check("res_rd", {13'b0, ResRd}, {13'b0, m_rd});
      check("res_err", {15'b0, ResErr}, {15'b0, m_err});
    end
    check("alu_a", AluA, m_a);
    check("alu_b", AluB, m_b);
    check("alu_op", {12'b0, AluOpcode}, {12'b0, m_op});
  end

  // ---------------- driver ----------------
  logic [15:0] r_data;
  logic [2:0]  r_rd;
  logic        r_err;
  int          r_lat;

  function automatic logic [15:0] f_alu(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] f_li(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h8, rd, imm};
  endfunction

  task automatic issue(input logic [15:0] ins, input int hold);
    int n;
    n = 0;
    while (!InstrReady && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!InstrReady) begin
      check("ready_timeout", {15'b0, InstrReady}, 16'h0001);
      return;
    end
    Instr      = ins;
    InstrValid = 1'b1;
    @(posedge clk);
    #1;
    Instr      = 16'($urandom);
    InstrValid = 1'($urandom_range(0, 1));
    r_lat = 0;
    do begin
      @(negedge clk);
      r_lat++;
    end while (!ResValid && r_lat < 8);
    if (!ResValid) begin
      check("res_timeout", {15'b0, ResValid}, 16'h0001);
      InstrValid = 1'b0;
      return;
    end
    r_data = ResData;
    r_rd   = ResRd;
    r_err  = ResErr;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      Instr      = 16'($urandom);
      InstrValid = 1'($urandom_range(0, 1));
    end
    InstrValid = 1'b0;
    ResReady   = 1'b1;
    @(posedge clk);
    #1;
    ResReady = 1'b0;
  endtask

  logic [15:0] exp_r0;
  logic [15:0] rnd_ins;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {15'b0, InstrReady}, 16'h0001);

    issue(f_li(3'd1, 9'h001), 0);
    issue(f_li(3'd2, 9'h002), 1);
    issue(f_alu(4'h0, 3'd3, 3'd1, 3'd2), 0);
    check("add_data", r_data, 16'h0003);
    check("add_rd", {13'b0, r_rd}, 16'h0003);
    check("add_latency", 16'(r_lat), 16'd2);

    issue(f_li(3'd1, 9'h0E7), 0);
    issue(f_li(3'd2, 9'h0A1), 0);
    issue(f_alu(4'h1, 3'd4, 3'd1, 3'd2), 2);
    check("sub_data", r_data, 16'h0046);
    issue(f_alu(4'h1, 3'd5, 3'd2, 3'd1), 0);
    check("sub_wrap", r_data, 16'hFFBA);

    issue(f_li(3'd1, 9'h00F), 0);
    issue(f_li(3'd2, 9'h004), 0);
    issue(f_alu(4'h2, 3'd3, 3'd1, 3'd2), 0);
    check("sll_data", r_data, 16'h00F0);
    issue(f_li(3'd1, 9'h1FF), 0);
    issue(f_li(3'd2, 9'h00F), 0);
    issue(f_alu(4'h3, 3'd6, 3'd1, 3'd2), 0);
    check("and_data", r_data, 16'h000F);

    // Illegal opcode aimed at R3 (holding 0x00F0), result held for 5 cycles.
    issue(f_alu(4'h7, 3'd3, 3'd1, 3'd2), 5);
    check("illegal_err", {15'b0, r_err}, 16'h0001);
    check("illegal_data", r_data, 16'h0000);
    check("illegal_rd", {13'b0, r_rd}, 16'h0003);
    issue(f_alu(4'h0, 3'd7, 3'd3, 3'd0), 0);
    check("illegal_no_write", r_data, 16'h00F0);

    // Reset asserted while ADD into R6 is in EXEC.
    Instr      = f_alu(4'h0, 3'd6, 3'd1, 3'd2);
    InstrValid = 1'b1;
    @(posedge clk);
    #1;
    InstrValid = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    check("abort_valid", {15'b0, ResValid}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", {15'b0, InstrReady}, 16'h0001);
    check("abort_valid2", {15'b0, ResValid}, 16'h0000);
    issue(f_alu(4'h0, 3'd5, 3'd6, 3'd6), 0);
    check("abort_r6_zero", r_data, 16'h0000);

    issue(f_li(3'd0, 9'h055), 0);
    check("r0_loadi_report", r_data, 16'h0055);
    issue(f_alu(4'h0, 3'd1, 3'd0, 3'd0), 0);
`ifdef ALU_SEQ_R0_ZERO_EN
    exp_r0 = 16'h0000;
`else
    exp_r0 = 16'h00AA;
`endif
    check("r0_add", r_data, exp_r0);

    for (int k = 0; k < 300; k++) begin
      rnd_ins = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rnd_ins[15:12] = 4'h0;
        1: rnd_ins[15:12] = 4'h1;
        2: rnd_ins[15:12] = 4'h2;
        3: rnd_ins[15:12] = 4'h3;
        4, 5, 6: rnd_ins[15:12] = 4'h8;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(rnd_ins, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
